// File: rtl/eg2000_tape_player.sv
// rtl/eg2000_tape_player.sv - virtual cassette deck: byte FIFO plus pulse-coded serialiser
// Each bit cell carries a clock pulse at its start; '1' cells add a data pulse at mid-cell.
module eg2000_tape_player #(
    parameter int CELL       = 1000,
    parameter int PULSE      = 125,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       play,
    input  logic [7:0] din,
    input  logic       dvalid,
    output logic       dready,
    output logic       tape,
    output logic       busy,
    output logic       underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(CELL);
    localparam int HALF  = CELL / 2;

    localparam logic [TW-1:0]         TICK_LAST = TW'(CELL - 1);
    localparam logic [TW-1:0]         PULSE_END = TW'(PULSE);
    localparam logic [TW-1:0]         DATA_BEG  = TW'(HALF);
    localparam logic [TW-1:0]         DATA_END  = TW'(HALF + PULSE);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q;
    logic [7:0]            shreg_q;
    logic [2:0]            bit_q;
    logic [TW-1:0]         tick_q;
    logic                  tape_q;
    logic                  busy_q;
    logic                  underrun_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            mem_q [DEPTH];

    logic fifo_empty;
    logic push;
    logic pop;
    logic byte_end;
    logic data_bit;
    logic tape_d;

    always_comb begin
        fifo_empty = (count_q == '0);
        dready     = (count_q != FULL_CNT);
        push       = dvalid && dready;
        byte_end   = (tick_q == TICK_LAST) && (bit_q == 3'd0);
        // The FIFO is read only when the FSM loads shreg: leaving IDLE or chaining bytes.
        pop        = ce && play && !fifo_empty && ((state_q == IDLE) || byte_end);
        data_bit   = shreg_q[bit_q];
        tape_d     = (tick_q < PULSE_END) ||
                     (data_bit && (tick_q >= DATA_BEG) && (tick_q < DATA_END));
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_q      <= '0;
            tick_q     <= '0;
            tape_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            underrun_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
                default: count_q <= count_q;
            endcase

            if (ce) begin
                case (state_q)
                    IDLE: begin
                        tape_q <= 1'b0;
                        if (pop) begin
                            state_q <= SHIFT;
                            shreg_q <= mem_q[rd_ptr_q];
                            bit_q   <= 3'd7;
                            tick_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        tape_q <= tape_d;
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            bit_q  <= bit_q - 3'd1;
                            if (bit_q == 3'd0) begin
                                if (pop) begin
                                    shreg_q <= mem_q[rd_ptr_q];
                                    bit_q   <= 3'd7;
                                end else begin
                                    state_q    <= IDLE;
                                    busy_q     <= 1'b0;
                                    underrun_q <= play;
                                end
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tape     = tape_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_eg2000_tape_player.sv
// tb/tb_eg2000_tape_player.sv - scoreboard bench: decodes the tape stream back into bytes
module tb_eg2000_tape_player;

    localparam int CELL   = 20;
    localparam int PULSE  = 3;
    localparam int HALF   = CELL / 2;
    localparam int CE_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       play = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dvalid = 1'b0;
    logic       dready;
    logic       tape;
    logic       busy;
    logic       underrun;

    eg2000_tape_player #(.CELL(CELL), .PULSE(PULSE), .DEPTH_LOG2(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .play     (play),
        .din      (din),
        .dvalid   (dvalid),
        .dready   (dready),
        .tape     (tape),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ce generator: free-running divider, or manual level when ce_auto is low
    logic ce_auto = 1'b0;
    logic ce_man = 1'b0;
    int   ce_cnt = 0;
    always @(negedge clock) begin
        #1;
        if (ce_auto) begin
            ce = (ce_cnt == 0);
            ce_cnt = (ce_cnt + 1) % CE_DIV;
        end else begin
            ce = ce_man;
        end
    end

    logic ce_seen = 1'b0;
    always @(posedge clock) ce_seen <= reset ? 1'b0 : ce;

    logic [7:0] sb[$];
    int   mon_off = 0;
    bit   in_cell = 0;
    bit   exp_start = 0;
    int   mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    logic cur_bit = 1'b0;
    int   bytes_out = 0;
    int   under_cnt = 0;
    int   hi_cnt = 0;

    always @(negedge clock) begin
        logic       expv;
        logic [7:0] e;
        if (reset) begin
            in_cell   = 0;
            exp_start = 0;
            mon_bits  = 0;
            mon_off   = 0;
        end else begin
            if (underrun) under_cnt++;
            if (tape) hi_cnt++;
            if (ce_seen) begin
                if (!in_cell) begin
                    if (exp_start) begin
                        check("no_gap", tape, 1);
                        exp_start = 0;
                    end
                    if (tape) begin
                        in_cell = 1;
                        mon_off = 0;
                    end
                end else begin
                    mon_off++;
                end
                if (in_cell) begin
                    if (mon_off == HALF) cur_bit = tape;
                    if (mon_off < PULSE) expv = 1'b1;
                    else if (mon_off >= HALF && mon_off < HALF + PULSE) expv = cur_bit;
                    else expv = 1'b0;
                    if (mon_off != HALF) check("cell_shape", tape, expv);
                    if (mon_off == CELL - 1) begin
                        mon_byte  = {mon_byte[6:0], cur_bit};
                        mon_bits++;
                        in_cell   = 0;
                        exp_start = busy;
                        if (mon_bits == 8) begin
                            mon_bits = 0;
                            bytes_out++;
                            if (sb.size() == 0) begin
                                check("sb_extra_byte", sb.size(), 1);
                            end else begin
                                e = sb.pop_front();
                                check("byte", mon_byte, e);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        logic acc;
        @(negedge clock);
        din = b;
        dvalid = 1'b1;
        acc = dready;
        if (acc) sb.push_back(b);
        @(negedge clock);
        dvalid = 1'b0;
        check("push_accept", acc, 1);
    endtask

    task automatic wait_busy(input logic v, input int maxc, input string tag);
        int n = 0;
        while (busy !== v && n < maxc) begin
            @(negedge clock);
            n++;
        end
        check(tag, busy, v);
    endtask

    task automatic settle();
        repeat (3) @(posedge clock);
        @(negedge clock);
    endtask

    int u0, b0, h0, n;
    logic acc;
    logic [7:0] fill [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        // T1 reset
        repeat (4) @(negedge clock);
        check("rst_tape", tape, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_dready", dready, 1);
        reset = 1'b0;
        play = 1'b1;
        ce_auto = 1'b1;
        h0 = hi_cnt;
        repeat (200) @(negedge clock);
        check("idle_tape_quiet", hi_cnt - h0, 0);
        check("idle_busy", busy, 0);

        // T2 single byte 0xA5
        ce_auto = 1'b0;
        play = 1'b0;
        repeat (4) @(negedge clock);
        push_byte(8'hA5);
        u0 = under_cnt; b0 = bytes_out;
        play = 1'b1;
        ce_auto = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ce_seen && n < 20);
        check("busy_first_ce", busy, 1);
        n = 0;
        while (!(mon_bits == 2 && in_cell && mon_off == 1) && n < 2000) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        ce_auto = 1'b0;
        ce_man = 1'b0;
        repeat (40) @(negedge clock);
        check("freeze_tape", tape, 1);
        check("freeze_busy", busy, 1);
        ce_auto = 1'b1;
        wait_busy(0, 2000, "t2_end");
        settle();
        check("t2_underrun", under_cnt - u0, 1);
        check("t2_bytes", bytes_out - b0, 1);

        // T3 back-to-back 0xFF, 0x00
        play = 1'b0;
        push_byte(8'hFF);
        push_byte(8'h00);
        u0 = under_cnt; b0 = bytes_out;
        play = 1'b1;
        wait_busy(1, 50, "t3_start");
        wait_busy(0, 4000, "t3_end");
        settle();
        check("t3_underrun", under_cnt - u0, 1);
        check("t3_bytes", bytes_out - b0, 2);

        // T4 FIFO full with dvalid held
        play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            din = fill[i];
            dvalid = 1'b1;
            acc = dready;
            if (acc) sb.push_back(fill[i]);
            if (i == 4) check("fifo_full_reject", acc, 0);
        end
        @(negedge clock);
        dvalid = 1'b0;
        check("dready_full", dready, 0);
        u0 = under_cnt; b0 = bytes_out;
        play = 1'b1;
        wait_busy(1, 50, "t4_start");
        wait_busy(0, 6000, "t4_end");
        settle();
        check("t4_bytes", bytes_out - b0, 4);
        check("t4_underrun", under_cnt - u0, 1);

        // simultaneous push and pop at count 3
        play = 1'b0;
        push_byte(8'h81);
        push_byte(8'h42);
        push_byte(8'h18);
        @(negedge clock);
        ce_auto = 1'b0;
        ce_man = 1'b0;
        repeat (2) @(negedge clock);
        play = 1'b1;
        ce_man = 1'b1;
        din = 8'h3C;
        dvalid = 1'b1;
        acc = dready;
        if (acc) sb.push_back(8'h3C);
        @(negedge clock);
        ce_man = 1'b0;
        dvalid = 1'b0;
        check("simul_accept", acc, 1);
        @(negedge clock);
        check("simul_count3", dready, 1);
        check("simul_busy", busy, 1);
        push_byte(8'h77);
        check("simul_now_full", dready, 0);
        b0 = bytes_out;
        ce_auto = 1'b1;
        wait_busy(0, 6000, "simul_end");
        settle();
        check("simul_bytes", bytes_out - b0, 5);

        // T5 stop mid-byte
        play = 1'b0;
        push_byte(8'h5A);
        push_byte(8'hC3);
        u0 = under_cnt; b0 = bytes_out;
        play = 1'b1;
        n = 0;
        while (!(mon_bits == 3 && in_cell && mon_off == 6) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        play = 1'b0;
        wait_busy(0, 2000, "t5_stop");
        settle();
        check("t5_no_underrun", under_cnt - u0, 0);
        check("t5_one_byte", bytes_out - b0, 1);
        check("t5_queued", sb.size(), 1);
        check("t5_dready", dready, 1);
        repeat (200) @(negedge clock);
        check("t5_stays_idle", busy, 0);
        play = 1'b1;
        wait_busy(1, 50, "t5_resume");
        wait_busy(0, 2000, "t5_end");
        settle();
        check("t5_bytes", bytes_out - b0, 2);
        check("t5_underrun", under_cnt - u0, 1);

        // T6 reset mid-pulse
        play = 1'b0;
        push_byte(8'hE7);
        push_byte(8'h99);
        play = 1'b1;
        n = 0;
        while (tape !== 1'b1 && n < 500) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        check("t6_tape_high", tape, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_tape_async", tape, 0);
        check("t6_busy_async", busy, 0);
        check("t6_fifo_empty", dready, 1);
        sb.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        h0 = hi_cnt; b0 = bytes_out;
        repeat (300) @(negedge clock);
        check("t6_quiet", hi_cnt - h0, 0);
        check("t6_busy", busy, 0);
        check("t6_no_bytes", bytes_out - b0, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
